apb_err_slv_logger: RTL

// - Parametrised APB default/error slave for the unmapped port of an APB demux.
// - Completes every valid transfer with PSLVERR after a programmable number of wait states.
// - Records the first offending transfer (address, direction) and counts all offending transfers.
// - Sits behind the APB demux default port; its capture/count outputs go to a system status block.

---
 rtl/apb_err_slv_logger.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/apb_err_slv_logger.sv
// APB default/error slave: answers every transfer with PSLVERR after WAIT_CYCLES wait states,
// logs the first offending transfer and counts all of them. Optional IRQ: APB_ERR_SLV_LOGGER_IRQ_EN.
module apb_err_slv_logger #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] RESP_DATA   = 32'hBADCAB1E,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic                    pwrite_i,
  input  logic [ADDR_WIDTH-1:0]   paddr_i,
  input  logic [DATA_WIDTH-1:0]   pwdata_i,
  input  logic [DATA_WIDTH/8-1:0] pstrb_i,
  output logic [DATA_WIDTH-1:0]   prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o,
  input  logic                    err_clr_i,
  output logic                    err_valid_o,
  output logic [ADDR_WIDTH-1:0]   err_addr_o,
  output logic                    err_write_o,
  output logic                    err_ovf_o,
  output logic [CNT_WIDTH-1:0]    err_cnt_o,
  output logic                    irq_o
);

  localparam int unsigned WCNT_WIDTH = 8;
  localparam logic [WCNT_WIDTH-1:0] WAIT_LOAD = WCNT_WIDTH'(WAIT_CYCLES);
  localparam logic [DATA_WIDTH-1:0] RESP_WORD = DATA_WIDTH'(RESP_DATA);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

  if (WAIT_CYCLES > 255) begin : g_wait_range_chk
    $error("apb_err_slv_logger: WAIT_CYCLES must be within 0..255");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state;
  logic [WCNT_WIDTH-1:0] wcnt;
  logic                  done;

  // Write data and strobes are never stored; an error slave has nowhere to put them.
  logic unused_inputs;
  assign unused_inputs = ^{pwdata_i, pstrb_i};

  // Transfer sequencer: a fresh setup phase is required for every transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      wcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (psel_i && !penable_i) begin
            wcnt  <= WAIT_LOAD;
            state <= (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          if (!psel_i) begin
            state <= S_IDLE;
          end else if (penable_i) begin
            wcnt <= wcnt - WCNT_WIDTH'(1);
            if (wcnt == WCNT_WIDTH'(1)) begin
              state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (!psel_i || penable_i) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign done      = (state == S_RESP) && psel_i && penable_i;
  assign pready_o  = done;
  assign pslverr_o = done;
  assign prdata_o  = (done && !pwrite_i) ? RESP_WORD : '0;

  // First-error capture and saturating count; a coincident clear restarts logging with this error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_valid_o <= 1'b0;
      err_addr_o  <= '0;
      err_write_o <= 1'b0;
      err_ovf_o   <= 1'b0;
      err_cnt_o   <= '0;
    end else if (done) begin
      if (err_clr_i) begin
        err_valid_o <= 1'b1;
        err_addr_o  <= paddr_i;
        err_write_o <= pwrite_i;
        err_ovf_o   <= 1'b0;
        err_cnt_o   <= CNT_WIDTH'(1);
      end else begin
        if (!err_valid_o) begin
          err_valid_o <= 1'b1;
          err_addr_o  <= paddr_i;
          err_write_o <= pwrite_i;
        end else begin
          err_ovf_o <= 1'b1;
        end
        if (err_cnt_o != CNT_MAX) begin
          err_cnt_o <= err_cnt_o + CNT_WIDTH'(1);
        end
      end
    end else if (err_clr_i) begin
      err_valid_o <= 1'b0;
      err_addr_o  <= '0;
      err_write_o <= 1'b0;
      err_ovf_o   <= 1'b0;
      err_cnt_o   <= '0;
    end
  end

`ifdef APB_ERR_SLV_LOGGER_IRQ_EN
  logic irq_q;

  // One-cycle pulse when an empty capture gets its first error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= done && !err_valid_o;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule
